// File: rtl/fir_sterowanie.sv
// fir_sterowanie: control FSM for one FIR filter pass per input sample.
// Ports: clk_b, rst_n (sync, low), start_probka, ile_wsp -> RAM/ROM addresses, accumulator controls, status.
module fir_sterowanie #(
    parameter int N_TAPS = 16,
    parameter int ADDR_W = $clog2(N_TAPS)
) (
    input  logic              clk_b,
    input  logic              rst_n,
    input  logic              start_probka,
    input  logic [ADDR_W:0]   ile_wsp,
    output logic              FSM_wpisz_probka,
    output logic [ADDR_W-1:0] adres_zapisu,
    output logic [ADDR_W-1:0] adres_probki,
    output logic [ADDR_W-1:0] adres_wsp,
    output logic              FSM_reset_Acc,
    output logic              FSM_Acc_en,
    output logic              FSM_Acc_zapis,
    output logic              zajety,
    output logic              gotowe,
    output logic              przepelnienie
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_FLUSH,
        S_COMMIT
    } stan_t;

    localparam logic [ADDR_W:0]   N_CNT   = (ADDR_W+1)'(N_TAPS);
    localparam logic [ADDR_W:0]   JEDEN   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] WSK_MAX = ADDR_W'(N_TAPS - 1);

    stan_t             stan;
    stan_t             stan_nast;
    logic [ADDR_W-1:0] wsk;
    logic [ADDR_W:0]   k_cnt;
    logic [ADDR_W:0]   t_cnt;
    logic [ADDR_W:0]   t_nowe;
    logic [ADDR_W:0]   wsk_x;
    logic [ADDR_W-1:0] roznica;
    logic              acc_en_q;
    logic              przep_q;

    // Zero or out-of-range tap counts fall back to the full delay line.
    always_comb begin
        t_nowe = ile_wsp;
        if (ile_wsp == '0 || ile_wsp > N_CNT) begin
            t_nowe = N_CNT;
        end
    end

    always_ff @(posedge clk_b) begin
        if (!rst_n) begin
            stan <= S_IDLE;
        end else begin
            stan <= stan_nast;
        end
    end

    always_comb begin
        stan_nast = stan;
        unique case (stan)
            S_IDLE: begin
                if (start_probka) begin
                    stan_nast = S_LOAD;
                end
            end
            S_LOAD: begin
                stan_nast = S_MAC;
            end
            S_MAC: begin
                if (k_cnt == t_cnt - JEDEN) begin
                    stan_nast = S_FLUSH;
                end
            end
            S_FLUSH: begin
                stan_nast = S_COMMIT;
            end
            S_COMMIT: begin
                stan_nast = S_IDLE;
            end
            default: begin
                stan_nast = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_b) begin
        if (!rst_n) begin
            wsk      <= '0;
            k_cnt    <= '0;
            t_cnt    <= N_CNT;
            acc_en_q <= 1'b0;
            przep_q  <= 1'b0;
        end else begin
            // Products appear one cycle after their address, so the
            // enable trails the MAC state by one cycle.
            acc_en_q <= (stan == S_MAC);
            przep_q  <= start_probka && (stan != S_IDLE);
            if (stan == S_IDLE) begin
                k_cnt <= '0;
                if (start_probka) begin
                    t_cnt <= t_nowe;
                end
            end
            if (stan == S_MAC) begin
                k_cnt <= k_cnt + JEDEN;
            end
            if (stan == S_COMMIT) begin
                wsk <= (wsk == WSK_MAX) ? '0 : wsk + 1'b1;
            end
        end
    end

    // Circular read address wsk-k, wrapped by adding N_TAPS
    // so non power-of-2 depths work.
    always_comb begin
        wsk_x = {1'b0, wsk};
        if (k_cnt > wsk_x) begin
            roznica = ADDR_W'(wsk_x + N_CNT - k_cnt);
        end else begin
            roznica = ADDR_W'(wsk_x - k_cnt);
        end
    end

    assign FSM_wpisz_probka = (stan == S_LOAD);
    assign FSM_reset_Acc    = (stan == S_LOAD);
    assign FSM_Acc_en       = acc_en_q;
    assign FSM_Acc_zapis    = (stan == S_COMMIT);
    assign gotowe           = (stan == S_COMMIT);
    assign zajety           = (stan != S_IDLE);
    assign przepelnienie    = przep_q;
    assign adres_zapisu     = (stan == S_LOAD) ? wsk : '0;
    assign adres_probki     = (stan == S_MAC) ? roznica : '0;
    assign adres_wsp        = (stan == S_MAC) ? k_cnt[ADDR_W-1:0] : '0;

endmodule
